// File: rtl/dcache_lookup_if.sv
// Bundle of every dcache_lookup handshake/bus signal.
// The master modport is the lookup controller; slave is the CPU/tag-array/hit-read/refill side.
interface dcache_lookup_if #(
    parameter int unsigned TAG_W = 20
);
    logic                cpu_req_valid;
    logic                cpu_req_ready;
    logic [TAG_W+11:0]   cpu_req_addr;
    logic                cpu_resp_valid;
    logic                cpu_resp_ready;
    logic [63:0]         cpu_resp_rdata;
    logic                lookup2tag_array_valid;
    logic [5:0]          lookup2tag_array_index;
    logic [8*TAG_W-1:0]  tag_array2lookup_tag;
    logic [7:0]          tag_array2lookup_vld;
    logic                ctrl2hit_read_valid;
    logic [5:0]          ctrl2hit_read_index;
    logic [2:0]          ctrl2hit_read_way;
    logic [5:0]          ctrl2hit_read_offset;
    logic                ctrl2hit_read_ready;
    logic [63:0]         hit_read2ctrl_rdata;
    logic                miss_valid;
    logic                miss_ready;
    logic [TAG_W+11:0]   miss_addr;
    logic                refill_done;

    modport master (
        input  cpu_req_valid, cpu_req_addr, cpu_resp_ready,
        input  tag_array2lookup_tag, tag_array2lookup_vld,
        input  hit_read2ctrl_rdata, miss_ready, refill_done,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        output lookup2tag_array_valid, lookup2tag_array_index,
        output ctrl2hit_read_valid, ctrl2hit_read_index, ctrl2hit_read_way,
        output ctrl2hit_read_offset, ctrl2hit_read_ready,
        output miss_valid, miss_addr
    );

    modport slave (
        output cpu_req_valid, cpu_req_addr, cpu_resp_ready,
        output tag_array2lookup_tag, tag_array2lookup_vld,
        output hit_read2ctrl_rdata, miss_ready, refill_done,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        input  lookup2tag_array_valid, lookup2tag_array_index,
        input  ctrl2hit_read_valid, ctrl2hit_read_index, ctrl2hit_read_way,
        input  ctrl2hit_read_offset, ctrl2hit_read_ready,
        input  miss_valid, miss_addr
    );
endinterface

// File: rtl/dcache_lookup.sv
// 8-way dcache lookup controller: tag compare, hit-read issue, miss/refill retry.
// Optional hit/miss counters enabled by defining DCACHE_LOOKUP_PERF_EN.
module dcache_lookup #(
    parameter int unsigned TAG_W = 20,
    parameter int unsigned WAYS  = 8
) (
    input  logic            clock,
    input  logic            reset,
    dcache_lookup_if.master bus
`ifdef DCACHE_LOOKUP_PERF_EN
    ,
    output logic [31:0]     perf_hit_cnt,
    output logic [31:0]     perf_miss_cnt
`endif
);
    localparam int unsigned AW = TAG_W + 12;

    typedef enum logic [2:0] {
        IDLE, TAG_RD, CMP, HIT_RD, DATA, RESP, MISS, REFILL
    } state_e;

    state_e         state_q;
    logic [AW-1:0]  addr_q;
    logic [63:0]    rdata_q;
    logic [2:0]     way_q;
    logic           req_ready_q;
    logic           tag_rd_q;
    logic           hr_valid_q;
    logic           hr_ready_q;
    logic           resp_valid_q;
    logic           miss_valid_q;

    logic [TAG_W-1:0] req_tag;
    logic [WAYS-1:0]  hit_vec;
    logic             hit_any;
    logic [2:0]       hit_way;

    assign req_tag = addr_q[AW-1:12];

    // Scanning from the top way down leaves the lowest matching way selected.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int unsigned n = 0; n < WAYS; n++) begin
            hit_vec[n] = bus.tag_array2lookup_vld[n] &
                         (bus.tag_array2lookup_tag[n*TAG_W +: TAG_W] == req_tag);
        end
        for (int unsigned n = WAYS; n > 0; n--) begin
            if (hit_vec[n-1]) hit_way = 3'(n - 1);
        end
        hit_any = |hit_vec;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rdata_q      <= '0;
            way_q        <= '0;
            req_ready_q  <= 1'b1;
            tag_rd_q     <= 1'b0;
            hr_valid_q   <= 1'b0;
            hr_ready_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            miss_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.cpu_req_valid) begin
                    addr_q      <= bus.cpu_req_addr;
                    req_ready_q <= 1'b0;
                    tag_rd_q    <= 1'b1;
                    state_q     <= TAG_RD;
                end
                TAG_RD: begin
                    tag_rd_q <= 1'b0;
                    state_q  <= CMP;
                end
                CMP: if (hit_any) begin
                    way_q      <= hit_way;
                    hr_valid_q <= 1'b1;
                    state_q    <= HIT_RD;
                end else begin
                    miss_valid_q <= 1'b1;
                    state_q      <= MISS;
                end
                HIT_RD: begin
                    hr_valid_q <= 1'b0;
                    hr_ready_q <= 1'b1;
                    state_q    <= DATA;
                end
                DATA: begin
                    hr_ready_q   <= 1'b0;
                    rdata_q      <= bus.hit_read2ctrl_rdata;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: if (bus.cpu_resp_ready) begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                MISS: if (bus.miss_ready) begin
                    miss_valid_q <= 1'b0;
                    state_q      <= REFILL;
                end
                REFILL: if (bus.refill_done) begin
                    tag_rd_q <= 1'b1;
                    state_q  <= TAG_RD;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_req_ready          = req_ready_q;
    assign bus.cpu_resp_valid         = resp_valid_q;
    assign bus.cpu_resp_rdata         = rdata_q;
    assign bus.lookup2tag_array_valid = tag_rd_q;
    assign bus.lookup2tag_array_index = addr_q[11:6];
    assign bus.ctrl2hit_read_valid    = hr_valid_q;
    assign bus.ctrl2hit_read_index    = addr_q[11:6];
    assign bus.ctrl2hit_read_way      = way_q;
    assign bus.ctrl2hit_read_offset   = addr_q[5:0];
    assign bus.ctrl2hit_read_ready    = hr_ready_q;
    assign bus.miss_valid             = miss_valid_q;
    assign bus.miss_addr              = {addr_q[AW-1:6], 6'b0};

`ifdef DCACHE_LOOKUP_PERF_EN
    logic [31:0] perf_hit_q, perf_hit_d;
    logic [31:0] perf_miss_q, perf_miss_d;

    always_comb begin
        perf_hit_d  = perf_hit_q;
        perf_miss_d = perf_miss_q;
        if (state_q == CMP) begin
            if (hit_any && perf_hit_q != '1)   perf_hit_d  = perf_hit_q + 32'd1;
            if (!hit_any && perf_miss_q != '1) perf_miss_d = perf_miss_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            perf_hit_q  <= perf_hit_d;
            perf_miss_q <= perf_miss_d;
        end
    end

    assign perf_hit_cnt  = perf_hit_q;
    assign perf_miss_cnt = perf_miss_q;
`endif
endmodule

// File: tb/tb_dcache_lookup.sv
// Directed self-checking bench for dcache_lookup with a 1-cycle tag array and hit-read stage model.
module tb_dcache_lookup;
    localparam int unsigned TAG_W = 20;
    localparam int unsigned AW    = TAG_W + 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_lookup_if #(.TAG_W(TAG_W)) bus ();

    logic [8*TAG_W-1:0] tb_tags;
    logic [7:0]         tb_vld;
    logic [63:0]        tb_rdata;
    int                 n_cmp = 0;
    int                 n_err = 0;

`ifdef DCACHE_LOOKUP_PERF_EN
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;
`endif

    dcache_lookup #(.TAG_W(TAG_W), .WAYS(8)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
`ifdef DCACHE_LOOKUP_PERF_EN
        ,
        .perf_hit_cnt  (perf_hit),
        .perf_miss_cnt (perf_miss)
`endif
    );

    // Tag array: data valid only in the cycle after the read strobe, junk otherwise.
    always @(posedge clk) begin
        if (bus.lookup2tag_array_valid) begin
            bus.tag_array2lookup_tag <= tb_tags;
            bus.tag_array2lookup_vld <= tb_vld;
        end else begin
            bus.tag_array2lookup_tag <= '1;
            bus.tag_array2lookup_vld <= '0;
        end
    end

    assign bus.hit_read2ctrl_rdata = bus.ctrl2hit_read_ready ? tb_rdata : 64'hBAD0_BAD0_BAD0_BAD0;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        rst_n = 1'b0;
        bus.cpu_req_valid = 1'b0; bus.cpu_req_addr = '0; bus.cpu_resp_ready = 1'b0;
        bus.miss_ready = 1'b0; bus.refill_done = 1'b0;
        tb_tags = '0; tb_vld = '0; tb_rdata = '0;
        tick; tick;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got=%b exp=1", bus.cpu_req_ready); end
        n_cmp++; if (bus.cpu_resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got=%b exp=0", bus.cpu_resp_valid); end
        n_cmp++; if (bus.lookup2tag_array_valid !== 1'b0) begin n_err++; $display("FAIL rst_tag_valid got=%b exp=0", bus.lookup2tag_array_valid); end
        n_cmp++; if (bus.ctrl2hit_read_valid !== 1'b0) begin n_err++; $display("FAIL rst_hr_valid got=%b exp=0", bus.ctrl2hit_read_valid); end
        n_cmp++; if (bus.ctrl2hit_read_ready !== 1'b0) begin n_err++; $display("FAIL rst_hr_ready got=%b exp=0", bus.ctrl2hit_read_ready); end
        n_cmp++; if (bus.miss_valid !== 1'b0) begin n_err++; $display("FAIL rst_miss_valid got=%b exp=0", bus.miss_valid); end
        n_cmp++; if (bus.cpu_resp_rdata !== 64'h0) begin n_err++; $display("FAIL rst_rdata got=%h exp=0", bus.cpu_resp_rdata); end
        n_cmp++; if (bus.miss_addr !== '0) begin n_err++; $display("FAIL rst_miss_addr got=%h exp=0", bus.miss_addr); end
        rst_n = 1'b1;
        tick; tick;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_err++; $display("FAIL idle_req_ready got=%b exp=1", bus.cpu_req_ready); end
        n_cmp++; if (bus.lookup2tag_array_valid !== 1'b0) begin n_err++; $display("FAIL idle_tag_valid got=%b exp=0", bus.lookup2tag_array_valid); end
`ifdef DCACHE_LOOKUP_PERF_EN
        n_cmp++; if (perf_hit !== 32'd0 || perf_miss !== 32'd0) begin n_err++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", perf_hit, perf_miss); end
`endif
    endtask

    task test_hit;
        tb_tags = '0; tb_tags[5*TAG_W +: TAG_W] = 20'h12345; tb_vld = 8'h20;
        tb_rdata = 64'hDEAD_BEEF_0000_1111;
        bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = {20'h12345, 6'h0A, 6'h28};
        tick; bus.cpu_req_valid = 1'b0;
        n_cmp++; if (bus.lookup2tag_array_valid !== 1'b1) begin n_err++; $display("FAIL hit_tag_valid got=%b exp=1", bus.lookup2tag_array_valid); end
        n_cmp++; if (bus.lookup2tag_array_index !== 6'h0A) begin n_err++; $display("FAIL hit_tag_index got=%h exp=0a", bus.lookup2tag_array_index); end
        n_cmp++; if (bus.cpu_req_ready !== 1'b0) begin n_err++; $display("FAIL hit_busy_ready got=%b exp=0", bus.cpu_req_ready); end
        tick;
        n_cmp++; if (bus.lookup2tag_array_valid !== 1'b0 || bus.ctrl2hit_read_valid !== 1'b0) begin n_err++; $display("FAIL hit_cmp_strobes got=%b%b exp=00", bus.lookup2tag_array_valid, bus.ctrl2hit_read_valid); end
        tick;
        n_cmp++; if (bus.ctrl2hit_read_valid !== 1'b1) begin n_err++; $display("FAIL hit_hr_valid got=%b exp=1", bus.ctrl2hit_read_valid); end
        n_cmp++; if (bus.ctrl2hit_read_index !== 6'h0A) begin n_err++; $display("FAIL hit_hr_index got=%h exp=0a", bus.ctrl2hit_read_index); end
        n_cmp++; if (bus.ctrl2hit_read_way !== 3'd5) begin n_err++; $display("FAIL hit_hr_way got=%0d exp=5", bus.ctrl2hit_read_way); end
        n_cmp++; if (bus.ctrl2hit_read_offset !== 6'h28) begin n_err++; $display("FAIL hit_hr_offset got=%h exp=28", bus.ctrl2hit_read_offset); end
        n_cmp++; if (bus.ctrl2hit_read_ready !== 1'b0) begin n_err++; $display("FAIL hit_hr_ready_early got=%b exp=0", bus.ctrl2hit_read_ready); end
        tick;
        n_cmp++; if (bus.ctrl2hit_read_valid !== 1'b0) begin n_err++; $display("FAIL hit_hr_valid_once got=%b exp=0", bus.ctrl2hit_read_valid); end
        n_cmp++; if (bus.ctrl2hit_read_ready !== 1'b1) begin n_err++; $display("FAIL hit_hr_ready got=%b exp=1", bus.ctrl2hit_read_ready); end
        n_cmp++; if (bus.cpu_resp_valid !== 1'b0) begin n_err++; $display("FAIL hit_resp_early got=%b exp=0", bus.cpu_resp_valid); end
        tick;
        n_cmp++; if (bus.cpu_resp_valid !== 1'b1) begin n_err++; $display("FAIL hit_resp_valid got=%b exp=1", bus.cpu_resp_valid); end
        n_cmp++; if (bus.cpu_resp_rdata !== 64'hDEAD_BEEF_0000_1111) begin n_err++; $display("FAIL hit_rdata got=%h exp=deadbeef00001111", bus.cpu_resp_rdata); end
        n_cmp++; if (bus.ctrl2hit_read_ready !== 1'b0) begin n_err++; $display("FAIL hit_hr_ready_drop got=%b exp=0", bus.ctrl2hit_read_ready); end
        bus.cpu_resp_ready = 1'b1;
        tick; bus.cpu_resp_ready = 1'b0;
        n_cmp++; if (bus.cpu_resp_valid !== 1'b0 || bus.cpu_req_ready !== 1'b1) begin n_err++; $display("FAIL hit_done got=%b%b exp=01", bus.cpu_resp_valid, bus.cpu_req_ready); end
    endtask

    task test_miss_retry;
        bus.refill_done = 1'b1;
        tick; bus.refill_done = 1'b0;
        n_cmp++; if (bus.lookup2tag_array_valid !== 1'b0 || bus.cpu_req_ready !== 1'b1) begin n_err++; $display("FAIL idle_refill_ignored got=%b%b exp=01", bus.lookup2tag_array_valid, bus.cpu_req_ready); end
        for (int w = 0; w < 8; w++) tb_tags[w*TAG_W +: TAG_W] = 20'h11111;
        tb_vld = 8'hFF; tb_rdata = 64'hCAFE_F00D_5555_AAAA;
        bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = {20'hABCDE, 6'h15, 6'h3F};
        tick; bus.cpu_req_valid = 1'b0;
        tick; tick;
        for (int c = 1; c <= 3; c++) begin
            n_cmp++; if (bus.miss_valid !== 1'b1) begin n_err++; $display("FAIL miss_valid_c%0d got=%b exp=1", c, bus.miss_valid); end
            n_cmp++; if (bus.miss_addr !== {20'hABCDE, 6'h15, 6'h00}) begin n_err++; $display("FAIL miss_addr_c%0d got=%h exp=%h", c, bus.miss_addr, {20'hABCDE, 6'h15, 6'h00}); end
            n_cmp++; if (bus.ctrl2hit_read_valid !== 1'b0) begin n_err++; $display("FAIL miss_no_hr_c%0d got=%b exp=0", c, bus.ctrl2hit_read_valid); end
            if (c == 3) bus.miss_ready = 1'b1;
            tick;
        end
        bus.miss_ready = 1'b0;
        n_cmp++; if (bus.miss_valid !== 1'b0) begin n_err++; $display("FAIL refill_miss_drop got=%b exp=0", bus.miss_valid); end
        tick;
        n_cmp++; if (bus.lookup2tag_array_valid !== 1'b0 || bus.cpu_req_ready !== 1'b0) begin n_err++; $display("FAIL refill_wait got=%b%b exp=00", bus.lookup2tag_array_valid, bus.cpu_req_ready); end
        tb_tags[0 +: TAG_W] = 20'hABCDE; tb_vld = 8'h01;
        bus.refill_done = 1'b1;
        tick; bus.refill_done = 1'b0;
        n_cmp++; if (bus.lookup2tag_array_valid !== 1'b1 || bus.lookup2tag_array_index !== 6'h15) begin n_err++; $display("FAIL retry_tag_rd got=%b/%h exp=1/15", bus.lookup2tag_array_valid, bus.lookup2tag_array_index); end
        tick; tick;
        n_cmp++; if (bus.ctrl2hit_read_valid !== 1'b1 || bus.ctrl2hit_read_way !== 3'd0 || bus.ctrl2hit_read_offset !== 6'h3F) begin n_err++; $display("FAIL retry_hr got=%b/%0d/%h exp=1/0/3f", bus.ctrl2hit_read_valid, bus.ctrl2hit_read_way, bus.ctrl2hit_read_offset); end
        tick; tick;
        n_cmp++; if (bus.cpu_resp_valid !== 1'b1 || bus.cpu_resp_rdata !== 64'hCAFE_F00D_5555_AAAA) begin n_err++; $display("FAIL retry_resp got=%b/%h exp=1/cafef00d5555aaaa", bus.cpu_resp_valid, bus.cpu_resp_rdata); end
        bus.cpu_resp_ready = 1'b1;
        tick; bus.cpu_resp_ready = 1'b0;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_err++; $display("FAIL retry_done got=%b exp=1", bus.cpu_req_ready); end
`ifdef DCACHE_LOOKUP_PERF_EN
        n_cmp++; if (perf_hit !== 32'd2 || perf_miss !== 32'd1) begin n_err++; $display("FAIL perf_after_miss got=%0d/%0d exp=2/1", perf_hit, perf_miss); end
`endif
    endtask

    task test_multi_hit;
        tb_tags = '0;
        tb_tags[0*TAG_W +: TAG_W] = 20'h00F0F;
        tb_tags[2*TAG_W +: TAG_W] = 20'h00F0F;
        tb_tags[6*TAG_W +: TAG_W] = 20'h00F0F;
        tb_vld = 8'h44; tb_rdata = 64'h0123_4567_89AB_CDEF;
        bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = {20'h00F0F, 6'h3F, 6'h08};
        tick; bus.cpu_req_valid = 1'b0;
        tick; tick;
        n_cmp++; if (bus.ctrl2hit_read_way !== 3'd2) begin n_err++; $display("FAIL multi_way got=%0d exp=2", bus.ctrl2hit_read_way); end
        n_cmp++; if (bus.ctrl2hit_read_index !== 6'h3F || bus.ctrl2hit_read_offset !== 6'h08) begin n_err++; $display("FAIL multi_idx_off got=%h/%h exp=3f/08", bus.ctrl2hit_read_index, bus.ctrl2hit_read_offset); end
        tick; tick;
        n_cmp++; if (bus.cpu_resp_rdata !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL multi_rdata got=%h exp=0123456789abcdef", bus.cpu_resp_rdata); end
        bus.cpu_resp_ready = 1'b1;
        tick; bus.cpu_resp_ready = 1'b0;
    endtask

    task test_backpressure;
        tb_tags = '0; tb_tags[7*TAG_W +: TAG_W] = 20'h07777; tb_vld = 8'h80;
        tb_rdata = 64'hFEDC_BA98_7654_3210;
        bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = {20'h07777, 6'h01, 6'h00};
        tick; bus.cpu_req_valid = 1'b0;
        tick; tick;
        n_cmp++; if (bus.ctrl2hit_read_way !== 3'd7) begin n_err++; $display("FAIL bp_way got=%0d exp=7", bus.ctrl2hit_read_way); end
        tick; tick;
        bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = {20'h12345, 6'h02, 6'h04};
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (bus.cpu_resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_c%0d got=%b exp=1", c, bus.cpu_resp_valid); end
            n_cmp++; if (bus.cpu_resp_rdata !== 64'hFEDC_BA98_7654_3210) begin n_err++; $display("FAIL bp_rdata_c%0d got=%h exp=fedcba9876543210", c, bus.cpu_resp_rdata); end
            n_cmp++; if (bus.cpu_req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready_c%0d got=%b exp=0", c, bus.cpu_req_ready); end
            tick;
        end
        n_cmp++; if (bus.lookup2tag_array_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_accept got=%b exp=0", bus.lookup2tag_array_valid); end
        bus.cpu_resp_ready = 1'b1; bus.cpu_req_valid = 1'b0;
        tick; bus.cpu_resp_ready = 1'b0;
        n_cmp++; if (bus.cpu_resp_valid !== 1'b0 || bus.cpu_req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b%b exp=01", bus.cpu_resp_valid, bus.cpu_req_ready); end
        tick;
        n_cmp++; if (bus.lookup2tag_array_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_stale_accept got=%b exp=0", bus.lookup2tag_array_valid); end
    endtask

    task test_reset_in_miss;
        for (int w = 0; w < 8; w++) tb_tags[w*TAG_W +: TAG_W] = 20'h11111;
        tb_vld = 8'hFF;
        bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = {20'h55555, 6'h2A, 6'h11};
        tick; bus.cpu_req_valid = 1'b0;
        tick; tick;
        n_cmp++; if (bus.miss_valid !== 1'b1) begin n_err++; $display("FAIL rim_miss_valid got=%b exp=1", bus.miss_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.miss_valid !== 1'b0) begin n_err++; $display("FAIL rim_async_drop got=%b exp=0", bus.miss_valid); end
        n_cmp++; if (bus.cpu_req_ready !== 1'b1) begin n_err++; $display("FAIL rim_async_ready got=%b exp=1", bus.cpu_req_ready); end
        tick; tick;
        rst_n = 1'b1;
        tick;
        n_cmp++; if (bus.cpu_req_ready !== 1'b1 || bus.miss_valid !== 1'b0 || bus.cpu_resp_valid !== 1'b0 || bus.lookup2tag_array_valid !== 1'b0) begin
            n_err++; $display("FAIL rim_idle got=%b%b%b%b exp=1000", bus.cpu_req_ready, bus.miss_valid, bus.cpu_resp_valid, bus.lookup2tag_array_valid);
        end
`ifdef DCACHE_LOOKUP_PERF_EN
        n_cmp++; if (perf_hit !== 32'd0 || perf_miss !== 32'd0) begin n_err++; $display("FAIL rim_perf got=%0d/%0d exp=0/0", perf_hit, perf_miss); end
`endif
    endtask

    initial begin
        test_reset;
        test_hit;
        test_miss_retry;
        test_multi_hit;
        test_backpressure;
        test_reset_in_miss;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/dcache_lookup.md
Name: dcache_lookup

Overview:
- Upstream neighbour of the dcache hit-read stage.
- Accepts one CPU load request at a time, reads the tag array, and compares all 8 ways.
- On a hit, issues the index/way/offset read to the hit-read stage, captures the returned 64-bit word and returns it to the CPU.
- On a miss, hands the request to the refill controller, waits for refill completion, then retries the lookup.

Parameters:
- TAG_W, 20, tag width; address is {tag[TAG_W-1:0], index[5:0], offset[5:0]}.
- WAYS, 8, associativity; fixed to 8 (way encoded in 3 bits).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  load request valid.
- cpu_req_ready  out  1  high only in IDLE.
- cpu_req_addr  in  TAG_W+12  load byte address.
- cpu_resp_valid  out  1  read data valid.
- cpu_resp_ready  in  1  CPU accepts response.
- cpu_resp_rdata  out  64  load data.
- lookup2tag_array_valid  out  1  tag read strobe.
- lookup2tag_array_index  out  6  set index.
- tag_array2lookup_tag  in  8*TAG_W  tags of way0..7; way n in bits [n*TAG_W +: TAG_W].
- tag_array2lookup_vld  in  8  line valid bits.
- ctrl2hit_read_valid  out  1  hit-read request.
- ctrl2hit_read_index  out  6  set index.
- ctrl2hit_read_way  out  3  hit way.
- ctrl2hit_read_offset  out  6  byte offset.
- ctrl2hit_read_ready  out  1  data capture strobe.
- hit_read2ctrl_rdata  in  64  selected doubleword.
- miss_valid  out  1  miss request to refill.
- miss_ready  in  1  refill accepts miss.
- miss_addr  out  TAG_W+12  line-aligned miss address (offset forced to 0).
- refill_done  in  1  one-cycle pulse: line installed.

Behaviour:
- States: IDLE, TAG_RD, CMP, HIT_RD, DATA, RESP, MISS, REFILL.
- Reset (async, reset low): state=IDLE; every output 0 except cpu_req_ready=1; request address register 0; response data register 0.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid, latch the address and go to TAG_RD.
- TAG_RD:
  - lookup2tag_array_valid=1 with the latched index.
  - Tag array returns tags/valids in the next cycle, with 1-cycle latency.
  - Go to CMP.
- CMP:
  - hit_vec[n] = vld[n] & (tag[n]==req_tag).
  - Any hit: go to HIT_RD; way = lowest set bit of hit_vec (multi-hit resolves to lowest way, no error).
  - No hit: go to MISS.
  - Tag inputs are sampled only in this cycle.
- HIT_RD:
  - ctrl2hit_read_valid=1 for exactly one cycle, with latched index, way and full 6-bit offset.
  - Go to DATA.
- DATA:
  - ctrl2hit_read_ready=1.
  - Capture hit_read2ctrl_rdata into the response register.
  - Go to RESP.
- RESP:
  - cpu_resp_valid=1 with the response register held stable.
  - On cpu_resp_ready, go to IDLE.
  - A new request is not accepted in the same cycle (cpu_req_ready=0).
- MISS:
  - miss_valid=1 and miss_addr stable until miss_ready.
  - On miss_ready, go to REFILL.
- REFILL:
  - Wait for refill_done, then go to TAG_RD (retry; the second lookup hits).
  - refill_done in any other state is ignored.
- Latency:
  - Hit: accept to cpu_resp_valid = 5 cycles (accept cycle, then TAG_RD, CMP, HIT_RD, DATA; resp valid in the following cycle).
  - Miss adds the refill time plus 2 (TAG_RD, CMP) to the 5-cycle hit latency.
- Reset asserted mid-operation: the request is dropped with no response; all handshake outputs drop immediately.
- Strobes (tag valid, hit-read valid, hit-read ready) are never asserted in the same cycle.

Optional Feature:
- Macro DCACHE_LOOKUP_PERF_EN.
- Defined:
  - Adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0].
  - Each counter increments once per CMP cycle with a hit or a miss respectively; the retry lookup after a refill counts as a hit.
  - Counters saturate at 32'hFFFF_FFFF.
  - Counters clear to 0 on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then idle: cpu_req_ready=1; all valids 0; cpu_resp_rdata=0.
- Hit, way 5: addr tag=0x12345, index=0x0A, offset=0x28; tags way5=0x12345, vld=8'h20.
  - Required: ctrl2hit_read_valid one cycle with index=0x0A, way=5, offset=0x28.
  - rdata 0xDEAD_BEEF_0000_1111 appears on cpu_resp_rdata 5 cycles after accept.
- Miss then retry: no tag match.
  - Required: miss_valid with miss_addr offset=0, held 3 cycles until miss_ready.
  - refill_done returns the block to TAG_RD; the retry hits way 0 and data is returned.
- Multi-hit: ways 2 and 6 both match and are valid -> ctrl2hit_read_way=2.
- Backpressure: cpu_resp_ready low for 4 cycles -> cpu_resp_valid and rdata stable; a cpu_req_valid during RESP is not accepted.
- Reset asserted in MISS: miss_valid drops to 0 asynchronously; after release, state is IDLE; with the PERF macro defined, both counters read 0.
